div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle unsigned restoring divider. Sits downstream of the 4-bit subtract stage and consumes its borrow/carry-out to resolve one quotient bit per cycle.
- Gives the ALU a DIV/MOD operation. Operand capture and result hand-back use a start/ready/done handshake.
- Trial subtraction uses the team's standard form: partial remainder + ~divisor with c_in=1. c_out=1 means no borrow.

Parameters:
- WIDTH, 4, operand / quotient / remainder width in bits (≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_in  input  1  request a division; sampled only while ready_out=1.
- a  input  WIDTH  dividend; captured when start is accepted.
- b  input  WIDTH  divisor; captured when start is accepted.
- ready_out  output  1  1 in IDLE only.
- done_out  output  1  one-cycle pulse; results valid.
- q_out  output  WIDTH  quotient, registered, held until next accept.
- r_out  output  WIDTH  remainder, registered, held until next accept.
- div_zero_out  output  1  divisor was zero; registered, held with results.

Behaviour:
- Reset (async, active-high): state=IDLE, q_out=0, r_out=0, div_zero_out=0, done_out=0, ready_out=1, internal counter/remainder=0.
- States:
  - IDLE: ready_out=1. start_in=1 at an edge = accept. Latch a and b, clear div_zero_out, rem=0, dividend shift reg=a, cnt=WIDTH-1. Go to CALC. If b==0, go to DONE instead.
  - CALC: ready_out=0. Each edge:
    - rs = {rem, dvd[MSB]}, WIDTH+1 bits.
    - diff = rs + ~{1'b0,b} + 1, over WIDTH+1 bits.
    - If carry-out=1: rem=diff[WIDTH-1:0], quotient bit=1. Else: rem=rs[WIDTH-1:0], quotient bit=0.
    - Quotient bit shifts into the LSB of the dvd register, which becomes the quotient.
    - Exactly WIDTH iterations. On the edge where cnt==0, load q_out and r_out and go to DONE.
  - DONE: done_out=1 for exactly one cycle. Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge E0 → done_out high in the cycle following edge E_WIDTH (WIDTH+1 cycles after acceptance). Divide-by-zero: done_out high in the cycle after E0.
- Divide-by-zero: q_out = all ones, r_out = a, div_zero_out=1.
- start_in while ready_out=0 is ignored. It is not queued, and operand changes have no effect.
- start_in held high through DONE: it is accepted again at the first IDLE edge. Back-to-back throughput is one result per WIDTH+2 cycles.
- q_out and r_out change only on the loading edge. They are stable while done_out=1 and afterwards.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and no done_out pulse is produced.
- All arithmetic is modulo 2^(WIDTH+1) internally. Outputs are truncated to WIDTH; no overflow is possible in unsigned mode.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - a and b are two's-complement.
  - Magnitudes are taken at accept; the core iterates unchanged.
  - Quotient is negated if the sign bits differ. Remainder takes the dividend's sign.
  - Most-negative ÷ -1 wraps: q_out = 100…0, r_out=0, no extra flag.
  - Divide-by-zero: q_out = all ones (-1), r_out = a.
  - Sign fix-up happens on the same edge that loads q_out/r_out, so latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesised.

Test Plan (WIDTH=4):
- Reset then a=13, b=3, start_in 1 cycle → ready_out=0 next cycle; done_out pulse 5 cycles after accept; q_out=4, r_out=1, div_zero_out=0.
- a=7, b=0 → done_out 1 cycle after accept; q_out=15, r_out=7, div_zero_out=1. A following a=6, b=2 clears the flag: q_out=3, r_out=0.
- Boundary sweep:
  - a=15, b=1 → q_out=15, r_out=0.
  - a=2, b=9 → q_out=0, r_out=2.
  - a=0, b=5 → q_out=0, r_out=0.
  - a=15, b=15 → q_out=1, r_out=0.
- Start a=9, b=2; pulse start_in with a=1, b=1 at cycle 2 of CALC → ignored; result q_out=4, r_out=1; then ready_out=1.
- Start a=14, b=3; assert rst in cycle 3 of CALC → outputs 0 and ready_out=1 immediately; no done_out pulse. A new division a=14, b=3 gives q_out=4, r_out=2.
- With DIV_SIGNED_EN:
  - a=-7 (1001), b=2 → q_out=1101 (-3), r_out=1111 (-1).
  - a=-8, b=-1 → q_out=1000, r_out=0.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider with start/ready/done handshake
//
// Purpose:
//   Produces the quotient and remainder of a / b. It resolves one quotient bit
//   per clock using a trial subtraction of the form
//   partial remainder + ~divisor + 1, where carry-out = 1 means no borrow.
//   A zero divisor is detected when the operands are accepted. In that case the
//   divider answers on the next cycle with q = all ones, r = a and the
//   div_zero flag set.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_in     division request, sampled only while ready_out = 1
//   a, b         dividend / divisor, captured on accept
//   ready_out    1 while idle
//   done_out     one-cycle pulse when q_out / r_out / div_zero_out are fresh
//   q_out        quotient, held until the next result load
//   r_out        remainder, held until the next result load
//   div_zero_out divisor was zero, held with the results
//
// Optional feature:
//   DIV_SIGNED_EN - treat a and b as two's complement. Operand magnitudes are
//   taken on accept and the core iterates unchanged. Quotient and remainder
//   signs are fixed on the same edge that loads the outputs.

module div_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready_out,
   output logic             done_out,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] r_out,
   output logic             div_zero_out
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dsr_q, dsr_d;    // divisor (magnitude)
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dz_q, dz_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   rs;
   logic [WIDTH+1:0] sum;
   logic             c_out;
   logic             unused_sum_msb;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] q_raw;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

`ifdef DIV_SIGNED_EN
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
`endif

   // One restoring step. The sum is one bit wider than the WIDTH+1 operands,
   // so that its top bit is the carry-out of the trial subtraction.
   always_comb begin
      rs             = {rem_q, dvd_q[WIDTH-1]};
      sum            = {1'b0, rs} + {1'b0, ~{1'b0, dsr_q}} + (WIDTH+2)'(1);
      c_out          = sum[WIDTH+1];
      unused_sum_msb = sum[WIDTH];
      rem_next       = c_out ? sum[WIDTH-1:0] : rs[WIDTH-1:0];
      q_raw          = {dvd_q[WIDTH-2:0], c_out};
   end

   // Operand magnitudes on accept and sign fix-up on result load.
   always_comb begin
`ifdef DIV_SIGNED_EN
      a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
      b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
      q_fix = neg_q_q ? (~q_raw + WIDTH'(1)) : q_raw;
      r_fix = neg_r_q ? (~rem_next + WIDTH'(1)) : rem_next;
`else
      a_mag = a;
      b_mag = b;
      q_fix = q_raw;
      r_fix = rem_next;
`endif
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               dz_d  = 1'b0;
               rem_d = '0;
               dvd_d = a_mag;
               dsr_d = b_mag;
               cnt_d = CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
               neg_q_d = a[WIDTH-1] ^ b[WIDTH-1];
               neg_r_d = a[WIDTH-1];
`endif
               if (b == '0) begin
                  // Zero divisor: answer immediately, skip the iterations.
                  q_d     = '1;
                  r_d     = a;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            rem_d = rem_next;
            dvd_d = q_raw;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               q_d     = q_fix;
               r_d     = r_fix;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake outputs are registered and track the state being entered.
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
         ready_q <= ready_d;
         done_q  <= done_d;
`ifdef DIV_SIGNED_EN
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

   assign ready_out    = ready_q;
   assign done_out     = done_q;
   assign q_out        = q_q;
   assign r_out        = r_q;
   assign div_zero_out = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq with a reference model

module tb_div_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_in;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready_out;
   logic         done_out;
   logic [W-1:0] q_out;
   logic [W-1:0] r_out;
   logic         div_zero_out;

   int total = 0;
   int bad   = 0;

   div_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_in     (start_in),
      .a            (a),
      .b            (b),
      .ready_out    (ready_out),
      .done_out     (done_out),
      .q_out        (q_out),
      .r_out        (r_out),
      .div_zero_out (div_zero_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Expected result straight from the arithmetic definition of division.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] eq, output logic [W-1:0] er,
                                 output logic ez);
      int sx;
      int sy;
      if (y == 0) begin
         eq = '1;
         er = x;
         ez = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         sx = int'($signed(x));
         sy = int'($signed(y));
`else
         sx = int'(x);
         sy = int'(y);
`endif
         eq = W'(sx / sy);
         er = W'(sx % sy);
         ez = 1'b0;
      end
   endfunction

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (ready_out !== 1'b1 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, ":ready_in"}, 32'(ready_out), 32'd1);
   endtask

   // One division: inj_at injects a stray start during CALC, rst_at aborts with reset.
   task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y, input string tag,
                          input int inj_at, input int rst_at);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
      logic [W-1:0] hold_q;
      logic [W-1:0] hold_r;
      int           k;
      int           lat;
      model(x, y, eq, er, ez);
      lat = (y == 0) ? 0 : W;
      wait_ready(tag);
      hold_q   = q_out;
      hold_r   = r_out;
      a        = x;
      b        = y;
      start_in = 1'b1;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      check({tag, ":ready_low"}, 32'(ready_out), 32'd0);
      k = 0;
      while (done_out !== 1'b1 && k < W + 5) begin
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check({tag, ":rst_q"}, 32'(q_out), 32'd0);
            check({tag, ":rst_r"}, 32'(r_out), 32'd0);
            check({tag, ":rst_ready"}, 32'(ready_out), 32'd1);
            check({tag, ":rst_done"}, 32'(done_out), 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int i = 0; i < W + 3; i++) begin
               @(posedge clk);
               #1;
               check({tag, ":no_done_after_rst"}, 32'(done_out), 32'd0);
            end
            return;
         end
         if (k == inj_at) begin
            a        = 4'd1;
            b        = 4'd1;
            start_in = 1'b1;
         end
         @(posedge clk);
         #1;
         start_in = 1'b0;
         k++;
         if (k == 1 && lat > 1) begin
            check({tag, ":hold_q_calc"}, 32'(q_out), 32'(hold_q));
            check({tag, ":hold_r_calc"}, 32'(r_out), 32'(hold_r));
         end
      end
      check({tag, ":latency"}, 32'(k), 32'(lat));
      check({tag, ":done"}, 32'(done_out), 32'd1);
      check({tag, ":q"}, 32'(q_out), 32'(eq));
      check({tag, ":r"}, 32'(r_out), 32'(er));
      check({tag, ":dz"}, 32'(div_zero_out), 32'(ez));
      @(posedge clk);
      #1;
      check({tag, ":done_pulse"}, 32'(done_out), 32'd0);
      check({tag, ":ready_after"}, 32'(ready_out), 32'd1);
      check({tag, ":q_held"}, 32'(q_out), 32'(eq));
      check({tag, ":r_held"}, 32'(r_out), 32'(er));
   endtask

   initial begin
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      int           first;
      int           second;

      rst      = 1'b1;
      start_in = 1'b0;
      a        = '0;
      b        = '0;
      #1;
      check("reset_q", 32'(q_out), 32'd0);
      check("reset_r", 32'(r_out), 32'd0);
      check("reset_dz", 32'(div_zero_out), 32'd0);
      check("reset_done", 32'(done_out), 32'd0);
      check("reset_ready", 32'(ready_out), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_div(4'd13, 4'd3, "d13_3", -1, -1);
      run_div(4'd7, 4'd0, "d7_0", -1, -1);
      run_div(4'd6, 4'd2, "d6_2", -1, -1);
      run_div(4'd15, 4'd1, "d15_1", -1, -1);
      run_div(4'd2, 4'd9, "d2_9", -1, -1);
      run_div(4'd0, 4'd5, "d0_5", -1, -1);
      run_div(4'd15, 4'd15, "d15_15", -1, -1);
      run_div(4'd9, 4'd2, "d9_2_inject", 1, -1);
      run_div(4'd14, 4'd3, "d14_3_rst", -1, 2);
      run_div(4'd14, 4'd3, "d14_3", -1, -1);
      run_div(4'd8, 4'd15, "d8_15", -1, -1);
      run_div(4'd9, 4'd0, "d9_0", -1, -1);

      for (int n = 0; n < 40; n++) begin
         rx = W'($urandom_range(0, (1 << W) - 1));
         ry = W'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (1 << W) - 1));
         run_div(rx, ry, $sformatf("rand%0d_%0d_%0d", n, rx, ry), -1, -1);
      end

      // start_in held high: re-accepted on the first idle edge after DONE.
      wait_ready("b2b");
      model(4'd13, 4'd3, eq, er, ez);
      a        = 4'd13;
      b        = 4'd3;
      start_in = 1'b1;
      first    = -1;
      second   = -1;
      for (int e = 1; e <= 3 * (W + 2) && second < 0; e++) begin
         @(posedge clk);
         #1;
         if (done_out === 1'b1) begin
            check("b2b_q", 32'(q_out), 32'(eq));
            check("b2b_r", 32'(r_out), 32'(er));
            if (first < 0) first = e;
            else second = e;
         end
      end
      start_in = 1'b0;
      check("b2b_period", 32'(second - first), 32'(W + 2));
      wait_ready("b2b_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
